// File: rtl/upg_word_assembler.sv
// UART programmer front end: header-counted byte stream to 32-bit
// program ROM word writes, with inter-byte timeout and sticky status.
module upg_word_assembler #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        byte_q, byte_d;
  logic [ADDR_W:0]   word_q, word_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [23:0]       shift_q, shift_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [15:0] hdr;
  logic        tmo_hit;
  logic        last_word;

  assign hdr       = {rx_data_i, cnt_q[7:0]};
  assign tmo_hit   = !rx_valid_i && (tmo_q == TMO_LAST);
  assign last_word = (32'(word_q) + 32'd1) == 32'(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    shift_d = shift_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_HDR0: begin
        if (rx_valid_i) begin
          cnt_d[7:0] = rx_data_i;
          tmo_d      = '0;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (rx_valid_i) begin
          cnt_d[15:8] = rx_data_i;
          tmo_d       = '0;
          if (hdr == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (32'(hdr) > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DATA: begin
        if (rx_valid_i) begin
          tmo_d   = '0;
          byte_d  = byte_q + 2'd1;
          shift_d = {rx_data_i, shift_q[23:8]};
          if (byte_q == 2'd3) begin
            wen_d  = 1'b1;
            dat_d  = {rx_data_i, shift_q};
            adr_d  = word_q[ADDR_W-1:0];
            word_d = word_q + (ADDR_W+1)'(1);
            if (last_word) state_d = S_DONE;
          end
        end else if (tmo_hit) begin
          // any partially assembled word is simply abandoned
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: done_d = 1'b1;
      S_ERR:  err_d  = 1'b1;
      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q <= S_HDR0;
      cnt_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

endmodule
